// File: rtl/idelay_pkg.sv
// Shared types for the idelay scan sequencer: FSM state encoding and bus widths.
package idelay_pkg;

    localparam int unsigned MASK_W = 8;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE_S  = 3'd1,
        TRIG      = 3'd2,
        WAIT_RISE = 3'd3,
        WAIT_FALL = 3'd4,
        NEXT      = 3'd5,
        FIN       = 3'd6
    } state_t;

endpackage

// File: rtl/idelay_scan_sequencer_seq_timer.sv
// Saturating cycle counter shared by the settle and scan-supervision waits.
module seq_timer #(
    parameter int unsigned TO_W   = 20,
    parameter int unsigned SETTLE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic at_settle,
    output logic timeout
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + TO_W'(1);
        end
    end

    assign at_settle = (count == TO_W'(SETTLE - 1));
    assign timeout   = (count == '1);

endmodule

// File: rtl/idelay_scan_sequencer.sv
// Steps idelay_scanner through a table of banyan masks with timeout supervision.
// Optional macro SCAN_SEQ_LOOP_EN adds a `loop` input that repeats the table.
module idelay_scan_sequencer
    import idelay_pkg::*;
#(
    parameter int unsigned N_STEP = 4,
    parameter int unsigned SETTLE = 8,
    parameter int unsigned TO_W   = 20
) (
    input  logic                     lb_clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
`ifdef SCAN_SEQ_LOOP_EN
    input  logic                     loop,
`endif
    input  logic [MASK_W*N_STEP-1:0] mask_table,
    input  logic [MASK_W-1:0]        host_mask,
    input  logic                     scan_running,
    output logic                     scan_trigger,
    output logic [MASK_W-1:0]        banyan_mask,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         step_idx,
    output logic [N_STEP-1:0]        fail_map
);

    state_t              state, state_next;
    logic [IDX_W-1:0]    step_next;
    logic [N_STEP-1:0]   fail_next;
    logic [N_STEP-1:0]   step_hot;
    logic [MASK_W-1:0]   sel_mask;
    logic                last_step;
    logic                at_settle, timeout, timer_clr;
    logic                trig_d, busy_d, done_d;
    logic [MASK_W-1:0]   mask_d;

    always_comb begin
        step_hot = '0;
        sel_mask = '0;
        for (int unsigned k = 0; k < N_STEP; k++) begin
            if (step_idx == IDX_W'(k)) begin
                step_hot[k] = 1'b1;
                sel_mask    = mask_table[MASK_W*k +: MASK_W];
            end
        end
    end

    assign last_step = (step_idx == IDX_W'(N_STEP - 1));
    // Every state change restarts the timer, so each wait sees a fresh count.
    assign timer_clr = (state_next != state) || (state == IDLE);

    seq_timer #(
        .TO_W   (TO_W),
        .SETTLE (SETTLE)
    ) u_timer (
        .clk       (lb_clk),
        .rst_n     (rst_n),
        .clr       (timer_clr),
        .at_settle (at_settle),
        .timeout   (timeout)
    );

    always_ff @(posedge lb_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            step_idx     <= '0;
            fail_map     <= '0;
            scan_trigger <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            banyan_mask  <= '0;
        end else begin
            state        <= state_next;
            step_idx     <= step_next;
            fail_map     <= fail_next;
            scan_trigger <= trig_d;
            busy         <= busy_d;
            done         <= done_d;
            banyan_mask  <= mask_d;
        end
    end

    always_comb begin
        state_next = state;
        step_next  = step_idx;
        fail_next  = fail_map;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETTLE_S;
                    step_next  = '0;
                    fail_next  = '0;
                end
            end
            SETTLE_S:  if (at_settle) state_next = TRIG;
            TRIG:      state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (scan_running) begin
                    state_next = WAIT_FALL;
                end else if (timeout) begin
                    fail_next  = fail_map | step_hot;
                    state_next = NEXT;
                end
            end
            WAIT_FALL: begin
                if (!scan_running) begin
                    state_next = NEXT;
                end else if (timeout) begin
                    fail_next  = fail_map | step_hot;
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (last_step) begin
`ifdef SCAN_SEQ_LOOP_EN
                    if (loop) begin
                        step_next  = '0;
                        state_next = SETTLE_S;
                    end else begin
                        state_next = FIN;
                    end
`else
                    state_next = FIN;
`endif
                end else begin
                    step_next  = step_idx + IDX_W'(1);
                    state_next = SETTLE_S;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort overrides any same-cycle progress, including a timeout flag.
        if (abort && state != IDLE && state != FIN) begin
            state_next = FIN;
            step_next  = step_idx;
            fail_next  = fail_map;
        end
    end

    always_comb begin
        trig_d = (state_next == TRIG);
        busy_d = (state_next != IDLE);
        done_d = (state_next == FIN);
        mask_d = (state == IDLE) ? host_mask : sel_mask;
    end

endmodule

// File: tb/tb_idelay_scan_sequencer.sv
// Randomised self-checking bench for idelay_scan_sequencer with a timing-level scanner model.
module tb_idelay_scan_sequencer;

    localparam int N_STEP = 4;
    localparam int SETTLE = 8;
    localparam int TO_W   = 6;
    localparam int TOUT   = (1 << TO_W) - 1;
    localparam int MAXC   = 3000;

    logic                  lb_clk       = 1'b0;
    logic                  rst_n        = 1'b0;
    logic                  start        = 1'b0;
    logic                  abort        = 1'b0;
    logic                  scan_running = 1'b0;
    logic [8*N_STEP-1:0]   mask_table   = 32'h0804_0201;
    logic [7:0]            host_mask    = 8'hAA;
    logic                  scan_trigger, busy, done;
    logic [7:0]            banyan_mask;
    logic [3:0]            step_idx;
    logic [N_STEP-1:0]     fail_map;
`ifdef SCAN_SEQ_LOOP_EN
    logic                  loop = 1'b0;
`endif

    idelay_scan_sequencer #(
        .N_STEP (N_STEP),
        .SETTLE (SETTLE),
        .TO_W   (TO_W)
    ) dut (
        .lb_clk       (lb_clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
`ifdef SCAN_SEQ_LOOP_EN
        .loop         (loop),
`endif
        .mask_table   (mask_table),
        .host_mask    (host_mask),
        .scan_running (scan_running),
        .scan_trigger (scan_trigger),
        .banyan_mask  (banyan_mask),
        .busy         (busy),
        .done         (done),
        .step_idx     (step_idx),
        .fail_map     (fail_map)
    );

    always #5 lb_clk = ~lb_clk;

    int cyc = 0;
    initial forever begin
        @(posedge lb_clk);
        cyc++;
    end

    int checks = 0;
    int failures = 0;

    // Scanner behaviour per step: 0 responds, 1 never rises, 2 rises and sticks high.
    int mode [N_STEP];
    int dly  [N_STEP];
    int hold [N_STEP];
    int sc_n = 0;
    int rise_at = -1;
    int fall_at = -1;

    initial begin
        int k;
        forever begin
            @(negedge lb_clk);
            if (scan_trigger) begin
                k = sc_n % N_STEP;
                sc_n++;
                case (mode[k])
                    0: begin rise_at = cyc + dly[k]; fall_at = rise_at + hold[k]; end
                    1: begin rise_at = -1; fall_at = -1; end
                    default: begin rise_at = cyc + dly[k]; fall_at = 32'h7fff_ffff; end
                endcase
            end
            scan_running = (rise_at >= 0) && (cyc >= rise_at) && (cyc < fall_at);
        end
    end

    int           trig_c[$];
    logic [7:0]   trig_m[$];
    int           trig_st[$];
    int           done_c[$];
    int           busy_after;
    int           busy_start_rel = -1;
    int           abort_step = -1;
    int           abort_at = -1;

    int           exp_c[$];
    logic [7:0]   exp_m[$];
    logic [N_STEP-1:0] exp_fail;
    int           exp_done;

    task automatic randomize_steps(input int maxhold_min);
        for (int k = 0; k < N_STEP; k++) begin
            mode[k] = 0;
            dly[k]  = $urandom_range(4, 1);
            hold[k] = $urandom_range(12, maxhold_min);
        end
    endtask

    task automatic quiesce();
        @(negedge lb_clk);
        rise_at = -1;
        fall_at = -1;
        repeat (3) @(negedge lb_clk);
    endtask

    // Expected trigger cycles from the step timing rules, anchored at the start cycle.
    task automatic model_run(input int s0, input int passes);
        int x, t;
        x = s0;
        exp_c.delete();
        exp_m.delete();
        exp_fail = '0;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < N_STEP; k++) begin
                t = x + 1 + SETTLE;
                exp_c.push_back(t);
                exp_m.push_back(mask_table[8*k +: 8]);
                case (mode[k])
                    0: x = t + dly[k] + hold[k] + 1;
                    1: begin x = t + 2 + TOUT; exp_fail[k] = 1'b1; end
                    default: begin x = t + dly[k] + 2 + TOUT; exp_fail[k] = 1'b1; end
                endcase
            end
        end
        exp_done = x + 1;
    endtask

    task automatic run_seq(output int s0, output bit finished);
        int         stab;
        logic [7:0] last_m;
        trig_c.delete(); trig_m.delete(); trig_st.delete(); done_c.delete();
        busy_after = -1;
        finished = 1'b0;
        sc_n = 0;
        @(negedge lb_clk);
        s0 = cyc;
        start = 1'b1;
        last_m = banyan_mask;
        stab = 1;
        for (int i = 0; i < MAXC; i++) begin
            @(negedge lb_clk);
            start = (busy_start_rel >= 0) && (cyc == s0 + busy_start_rel);
            abort = (cyc == abort_at);
            if (banyan_mask === last_m) stab++; else stab = 1;
            last_m = banyan_mask;
            if (scan_trigger) begin
                trig_c.push_back(cyc);
                trig_m.push_back(banyan_mask);
                trig_st.push_back(stab);
                if (abort_step == trig_c.size() - 1) abort_at = cyc + dly[abort_step] + 2;
            end
            if (done) done_c.push_back(cyc);
            if (done_c.size() > 0 && cyc == done_c[0] + 1) busy_after = int'(busy);
`ifdef SCAN_SEQ_LOOP_EN
            if (trig_c.size() >= 9) loop = 1'b0;
`endif
            if (done_c.size() > 0 && cyc == done_c[0] + 3) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        busy_start_rel = -1;
    endtask

    task automatic test_sequence(input string name, input int passes);
        int s0;
        bit fin;
        int n;
        run_seq(s0, fin);
        model_run(s0, passes);
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL %s completion: no done within %0d cycles", name, MAXC);
        end
        checks++;
        if (trig_c.size() !== exp_c.size()) begin
            failures++;
            $display("FAIL %s trigger_count: got %0d expected %0d", name, trig_c.size(), exp_c.size());
        end
        n = (trig_c.size() < exp_c.size()) ? trig_c.size() : exp_c.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (trig_c[i] !== exp_c[i] || trig_m[i] !== exp_m[i] || trig_st[i] < SETTLE) begin
                failures++;
                $display("FAIL %s trigger[%0d]: got cycle %0d mask %h stable %0d expected cycle %0d mask %h stable>=%0d",
                         name, i, trig_c[i] - s0, trig_m[i], trig_st[i], exp_c[i] - s0, exp_m[i], SETTLE);
            end
        end
        checks++;
        if (done_c.size() !== 1 || (done_c.size() > 0 && done_c[0] !== exp_done)) begin
            failures++;
            $display("FAIL %s done: got %0d pulses first at %0d expected 1 pulse at %0d",
                     name, done_c.size(), (done_c.size() > 0) ? done_c[0] - s0 : -1, exp_done - s0);
        end
        checks++;
        if (fail_map !== exp_fail) begin
            failures++;
            $display("FAIL %s fail_map: got %b expected %b", name, fail_map, exp_fail);
        end
        checks++;
        if (step_idx !== 4'(N_STEP - 1)) begin
            failures++;
            $display("FAIL %s step_idx: got %0d expected %0d", name, step_idx, N_STEP - 1);
        end
        checks++;
        if (busy_after !== 0) begin
            failures++;
            $display("FAIL %s busy_after_done: got %0d expected 0", name, busy_after);
        end
        checks++;
        if (banyan_mask !== host_mask) begin
            failures++;
            $display("FAIL %s mask_after: got %h expected %h", name, banyan_mask, host_mask);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge lb_clk);
        checks++;
        if ({scan_trigger, busy, done} !== 3'b000 || step_idx !== 4'd0 || fail_map !== '0 || banyan_mask !== 8'h00) begin
            failures++;
            $display("FAIL reset_values: got trig=%b busy=%b done=%b idx=%0d fail=%b mask=%h expected all zero",
                     scan_trigger, busy, done, step_idx, fail_map, banyan_mask);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge lb_clk);
        checks++;
        if (banyan_mask !== host_mask || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_mask: got mask=%h busy=%b expected mask=%h busy=0", banyan_mask, busy, host_mask);
        end
    endtask

    task automatic test_normal();
        quiesce();
        randomize_steps(1);
        test_sequence("normal", 1);
    endtask

    task automatic test_missing_rise();
        quiesce();
        randomize_steps(1);
        mode[2] = 1;
        test_sequence("missing_rise", 1);
    endtask

    task automatic test_stuck_high();
        quiesce();
        randomize_steps(1);
        mode[3] = 2;
        test_sequence("stuck_high", 1);
        quiesce();
        randomize_steps(1);
    endtask

    task automatic test_abort();
        int s0;
        bit fin;
        quiesce();
        randomize_steps(4);
        busy_start_rel = 4;
        abort_step = 1;
        abort_at = -1;
        run_seq(s0, fin);
        model_run(s0, 1);
        checks++;
        if (!fin || trig_c.size() !== 2) begin
            failures++;
            $display("FAIL abort_triggers: got %0d triggers finished=%0d expected 2 triggers finished=1", trig_c.size(), fin);
        end
        if (trig_c.size() >= 2) begin
            checks++;
            if (trig_c[0] !== exp_c[0] || trig_c[1] !== exp_c[1]) begin
                failures++;
                $display("FAIL abort_trigger_cycles: got %0d,%0d expected %0d,%0d",
                         trig_c[0] - s0, trig_c[1] - s0, exp_c[0] - s0, exp_c[1] - s0);
            end
        end
        checks++;
        if (done_c.size() !== 1 || (done_c.size() > 0 && done_c[0] !== abort_at + 1)) begin
            failures++;
            $display("FAIL abort_done: got %0d pulses first at %0d expected 1 pulse at %0d",
                     done_c.size(), (done_c.size() > 0) ? done_c[0] - s0 : -1, abort_at + 1 - s0);
        end
        checks++;
        if (step_idx !== 4'd1 || fail_map !== '0 || busy_after !== 0) begin
            failures++;
            $display("FAIL abort_state: got idx=%0d fail=%b busy_after=%0d expected idx=1 fail=0000 busy_after=0",
                     step_idx, fail_map, busy_after);
        end
        abort_step = -1;
        abort_at = -1;
        repeat (16) @(negedge lb_clk);
    endtask

    task automatic test_reset_mid();
        int s0;
        int seen;
        quiesce();
        randomize_steps(1);
        sc_n = 0;
        @(negedge lb_clk);
        s0 = cyc;
        start = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge lb_clk);
            start = 1'b0;
            if (scan_trigger || done) seen++;
        end
        rst_n = 1'b0;
        @(negedge lb_clk);
        checks++;
        if ({scan_trigger, busy, done} !== 3'b000 || step_idx !== 4'd0 || fail_map !== '0 || banyan_mask !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_values: got trig=%b busy=%b done=%b idx=%0d fail=%b mask=%h expected all zero",
                     scan_trigger, busy, done, step_idx, fail_map, banyan_mask);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge lb_clk);
            if (scan_trigger || done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got %0d trigger/done/busy cycles expected 0", seen);
        end
        checks++;
        if (banyan_mask !== host_mask) begin
            failures++;
            $display("FAIL reset_mid_mask: got %h expected %h", banyan_mask, host_mask);
        end
        test_normal();
    endtask

`ifdef SCAN_SEQ_LOOP_EN
    task automatic test_loop();
        quiesce();
        randomize_steps(1);
        loop = 1'b1;
        test_sequence("loop", 3);
        loop = 1'b0;
    endtask
`endif

    initial begin
        for (int k = 0; k < N_STEP; k++) begin
            mode[k] = 0; dly[k] = 2; hold[k] = 10;
        end
        test_reset();
        test_normal();
        test_normal();
        test_missing_rise();
        test_stuck_high();
        test_abort();
        test_reset_mid();
        test_normal();
`ifdef SCAN_SEQ_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
